// File: rtl/mips_ifu_pkg.sv
// -----------------------------------------------------------------------------
// mips_ifu_pkg
// Shared types and constants for the MIPS instruction-fetch unit.
//   ifu_state_e : fetch FSM states (FETCH, HOLD, DROP)
//   INSTR_W     : instruction / address width
//   NOP_INSTR   : bubble presented to IF/ID when no valid instruction exists
// -----------------------------------------------------------------------------
package mips_ifu_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'd0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding to instruction memory
        HOLD  = 2'd1,   // instruction buffered while the pipeline is stalled
        DROP  = 2'd2    // in-flight response belongs to a redirected-away PC
    } ifu_state_e;

endpackage

// File: rtl/ifu_watchdog.sv
// -----------------------------------------------------------------------------
// ifu_watchdog
// Counts consecutive cycles in which a fetch request is outstanding without
// an acknowledge. When the count reaches LIMIT a single-cycle error pulse is
// raised and the count restarts; the request itself is not disturbed.
// Ports:
//   CLK     in  clock
//   rst_n   in  asynchronous active-low reset
//   req_i   in  fetch request currently asserted
//   ack_i   in  memory acknowledge
//   err_o   out timeout pulse (one cycle)
// -----------------------------------------------------------------------------
module ifu_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic req_i,
    input  logic ack_i,
    output logic err_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign err_o = (cnt_q == 32'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (ack_i || err_o) begin
            cnt_d = '0;
        end else if (req_i) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, runs a
// req/ack handshake with instruction memory, feeds RDF/PCPlus4F into IF/ID,
// inserts NOP bubbles while memory is slow, buffers a returned instruction
// while IF is stalled and applies branch/jump redirects from decode, throwing
// away any stale in-flight fetch.
//
// Optional feature: define IFU_WATCHDOG_EN to enable the request-timeout
// watchdog (ifu_watchdog, threshold WDT_LIMIT). Without it FetchErr is 0.
//
// Ports:
//   CLK, rst_n            clock, asynchronous active-low reset
//   StallF                hold PC and instruction
//   PCSrcD / PCBranchD    taken-branch redirect and target
//   JumpD / PCJumpD       jump redirect and target (wins over branch)
//   imem_req / imem_addr  fetch request and word-aligned address
//   imem_ack / imem_rdata one-cycle acknowledge with returned instruction
//   RDF, PCPlus4F         instruction (NOP when invalid) and its PC+4
//   InstrValidF           RDF carries a real instruction
//   FetchErr              watchdog timeout pulse
// -----------------------------------------------------------------------------
module mips_fetch_unit
    import mips_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          WDT_LIMIT = 255
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               StallF,
    input  logic               PCSrcD,
    input  logic [31:0]        PCBranchD,
    input  logic               JumpD,
    input  logic [31:0]        PCJumpD,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] RDF,
    output logic [31:0]        PCPlus4F,
    output logic               InstrValidF,
    output logic               FetchErr
);

    ifu_state_e         state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic [INSTR_W-1:0] instr_buf_q, instr_buf_d;

    logic        redirect;
    logic [31:0] target;

    // A stalled decode stage may be holding a stale branch decision, so
    // redirects are only honoured when IF is free to move.
    assign redirect = !StallF && (JumpD || PCSrcD);
    assign target   = (JumpD ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;

    assign imem_addr = pc_q;
    assign PCPlus4F  = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        instr_buf_d = instr_buf_q;
        RDF         = NOP_INSTR;
        InstrValidF = 1'b0;
        imem_req    = 1'b1;

        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returned word is on the wrong path; refetch at target.
                        pc_d = target;
                    end else if (StallF) begin
                        instr_buf_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        RDF         = imem_rdata;
                        InstrValidF = 1'b1;
                        pc_d        = pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    // The memory still owes a response for pc_q; park the
                    // target until that response has been absorbed.
                    pend_pc_d = target;
                    state_d   = DROP;
                end
            end

            HOLD: begin
                imem_req    = 1'b0;
                RDF         = instr_buf_q;
                InstrValidF = 1'b1;
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!StallF) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end

            DROP: begin
                if (imem_ack) begin
                    pc_d    = redirect ? target : pend_pc_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    pend_pc_d = target;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            pend_pc_q   <= '0;
            instr_buf_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            instr_buf_q <= instr_buf_d;
        end
    end

`ifdef IFU_WATCHDOG_EN
    ifu_watchdog #(
        .LIMIT (WDT_LIMIT)
    ) u_watchdog (
        .CLK   (CLK),
        .rst_n (rst_n),
        .req_i (imem_req),
        .ack_i (imem_ack),
        .err_o (FetchErr)
    );
`else
    logic unused_wdt_limit;
    assign unused_wdt_limit = (WDT_LIMIT == 0);
    assign FetchErr         = 1'b0;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;
    import mips_ifu_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        StallF, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] RDF, PCPlus4F;
    logic        InstrValidF, FetchErr;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mips_fetch_unit #(
        .RESET_PC  (RPC),
        .WDT_LIMIT (4)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .StallF      (StallF),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .JumpD       (JumpD),
        .PCJumpD     (PCJumpD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .RDF         (RDF),
        .PCPlus4F    (PCPlus4F),
        .InstrValidF (InstrValidF),
        .FetchErr    (FetchErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic ack, input logic [31:0] rd, input logic stall);
        @(negedge CLK);
        imem_ack   = ack;
        imem_rdata = rd;
        StallF     = stall;
        #1;
    endtask

    initial begin
        logic exp_err;
        rst_n = 1'b0; StallF = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
        PCBranchD = '0; PCJumpD = '0; imem_ack = 1'b0; imem_rdata = '0;

        // Reset state
        #12;
        chk("rst_req",   32'(imem_req), 32'd1);
        chk("rst_addr",  imem_addr, RPC);
        chk("rst_rdf",   RDF, 32'd0);
        chk("rst_pcp4",  PCPlus4F, RPC + 32'd4);
        chk("rst_valid", 32'(InstrValidF), 32'd0);
        chk("rst_err",   32'(FetchErr), 32'd0);
        @(negedge CLK); rst_n = 1'b1;

        // Zero-wait memory: one instruction per cycle
        drive(1'b1, 32'h1111_1111, 1'b0);
        chk("zw0_addr", imem_addr, 32'h0040_0000);
        chk("zw0_rdf",  RDF, 32'h1111_1111);
        chk("zw0_vld",  32'(InstrValidF), 32'd1);
        drive(1'b1, 32'h2222_2222, 1'b0);
        chk("zw1_addr", imem_addr, 32'h0040_0004);
        chk("zw1_rdf",  RDF, 32'h2222_2222);
        chk("zw1_vld",  32'(InstrValidF), 32'd1);
        drive(1'b1, 32'h3333_3333, 1'b0);
        chk("zw2_addr", imem_addr, 32'h0040_0008);
        chk("zw2_vld",  32'(InstrValidF), 32'd1);

        // 3-cycle latency at 0x40000C: two bubbles then the instruction
        drive(1'b0, 32'hXXXX_XXXX, 1'b0);
        chk("lat0_rdf", RDF, 32'd0);
        chk("lat0_vld", 32'(InstrValidF), 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        chk("lat1_rdf", RDF, 32'd0);
        chk("lat1_vld", 32'(InstrValidF), 32'd0);
        drive(1'b1, 32'hAAAA_0001, 1'b0);
        chk("lat2_addr", imem_addr, 32'h0040_000C);
        chk("lat2_rdf",  RDF, 32'hAAAA_0001);
        chk("lat2_pcp4", PCPlus4F, 32'h0040_0010);
        chk("lat2_vld",  32'(InstrValidF), 32'd1);

        // Ack during stall -> HOLD for 4 cycles, then fetch PC+4
        drive(1'b1, 32'hBBBB_0002, 1'b1);
        chk("stall_addr", imem_addr, 32'h0040_0010);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, (i < 3));
            chk("hold_rdf", RDF, 32'hBBBB_0002);
            chk("hold_vld", 32'(InstrValidF), 32'd1);
            chk("hold_req", 32'(imem_req), 32'd0);
            chk("hold_pcp4", PCPlus4F, 32'h0040_0014);
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("rel_addr", imem_addr, 32'h0040_0014);
        chk("rel_req",  32'(imem_req), 32'd1);

        // Branch during outstanding request -> DROP, stale ack discarded
        PCSrcD = 1'b1; PCBranchD = 32'h0000_0100;
        #1;
        chk("br_rdf", RDF, 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        PCSrcD = 1'b0; PCBranchD = 32'h0;
        #1;
        chk("drop_req",  32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'h0040_0014);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("drop_rdf", RDF, 32'd0);
        chk("drop_vld", 32'(InstrValidF), 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        chk("br_tgt_addr", imem_addr, 32'h0000_0100);

        // Jump and branch together on an acked fetch; jump wins, target aligned
        drive(1'b1, 32'hCCCC_0003, 1'b0);
        JumpD = 1'b1; PCJumpD = 32'h0000_0203; PCSrcD = 1'b1; PCBranchD = 32'h0000_0300;
        #1;
        chk("jb_rdf", RDF, 32'd0);
        chk("jb_vld", 32'(InstrValidF), 32'd0);
        drive(1'b1, 32'h0, 1'b0);
        JumpD = 1'b1; PCJumpD = 32'hFFFF_FFFC; PCSrcD = 1'b0; PCBranchD = 32'h0;
        #1;
        chk("jb_addr", imem_addr, 32'h0000_0200);
        drive(1'b1, 32'h1234_5678, 1'b0);
        JumpD = 1'b0; PCJumpD = 32'h0;
        #1;

        // PC wrap at 0xFFFFFFFC
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pcp4", PCPlus4F, 32'h0000_0000);
        chk("wrap_rdf",  RDF, 32'h1234_5678);
        drive(1'b0, 32'h0, 1'b0);
        chk("wrap_next", imem_addr, 32'h0000_0000);

        // Reset mid-request returns to RESET_PC immediately
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", imem_addr, RPC);
        chk("mid_rst_req",  32'(imem_req), 32'd1);
        @(negedge CLK); rst_n = 1'b1;
        drive(1'b1, 32'h5555_5555, 1'b0);
        chk("late_ack_addr", imem_addr, RPC);
        chk("late_ack_rdf",  RDF, 32'h5555_5555);

        // Redirect out of HOLD drops the buffered word
        drive(1'b1, 32'h6666_6666, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        JumpD = 1'b1; PCJumpD = 32'h0000_0040;
        #1;
        chk("hredir_rdf", RDF, 32'h6666_6666);
        drive(1'b0, 32'h0, 1'b0);
        JumpD = 1'b0; PCJumpD = 32'h0;
        #1;
        chk("hredir_addr", imem_addr, 32'h0000_0040);

        // Unacknowledged request: watchdog pulses every 5 cycles when enabled
        for (int i = 0; i < 10; i++) begin
            if (i > 0) drive(1'b0, 32'h0, 1'b0);
`ifdef IFU_WATCHDOG_EN
            exp_err = ((i % 5) == 4);
`else
            exp_err = 1'b0;
`endif
            chk("wdt_err",  32'(FetchErr), 32'(exp_err));
            chk("wdt_addr", imem_addr, 32'h0000_0040);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
